// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the multdiv unit: launches one
// mult/div, waits for ready (or times out) and issues a single writeback.
module multdiv_ctrl #(
   parameter logic [4:0]  RSTATUS_REG  = 5'd30,
   parameter logic [31:0] MUL_EXC_CODE = 32'd4,
   parameter logic [31:0] DIV_EXC_CODE = 32'd5,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_is_div,
   input  logic [31:0] in_opA,
   input  logic [31:0] in_opB,
   input  logic [4:0]  in_rd,
   output logic        stall,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [31:0]      op_a_q, op_b_q, result_q;
   logic             is_div_q, exc_q;
   logic [4:0]       rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             timed_out;

   assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand/result latches and the BUSY cycle counter (1 in the first BUSY cycle).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_a_q   <= '0;
         op_b_q   <= '0;
         is_div_q <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_q <= '0;
               if (in_valid) begin
                  op_a_q   <= in_opA;
                  op_b_q   <= in_opB;
                  is_div_q <= in_is_div;
                  rd_q     <= in_rd;
               end
            end
            START: cnt_q <= CNT_W'(1);
            BUSY: begin
               if (md_resultRDY) begin
                  result_q <= md_result;
                  exc_q    <= md_exception;
               end else if (timed_out) begin
                  result_q <= '0;
                  exc_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      stall        = 1'b0;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      md_operandA  = op_a_q;
      md_operandB  = op_b_q;
      case (state)
         IDLE: begin
            // Gated by reset so stall drops immediately while reset is held.
            stall = in_valid & reset;
            if (in_valid) state_nxt = START;
         end
         START: begin
            stall        = 1'b1;
            md_ctrl_MULT = ~is_div_q;
            md_ctrl_DIV  = is_div_q;
            state_nxt    = BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (md_resultRDY || timed_out) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
            if (exc_q) begin
               wb_valid = 1'b1;
               wb_rd    = RSTATUS_REG;
               wb_data  = is_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;
            end else begin
               wb_valid = (rd_q != '0);
               wb_rd    = rd_q;
               wb_data  = result_q;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: transaction-driven expectations checked every cycle,
// plus literal checks on the directed scenarios.
module tb_multdiv_ctrl;

   localparam int TMO = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_is_div = 1'b0;
   logic [31:0] in_opA = '0, in_opB = '0;
   logic [4:0]  in_rd = '0;
   logic        stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid;
   logic [31:0] md_operandA, md_operandB, wb_data;
   logic [4:0]  wb_rd;
   logic [31:0] md_result = '0;
   logic        md_exception = 1'b0, md_resultRDY = 1'b0;

   always #5 clock = ~clock;

   multdiv_ctrl #(.RSTATUS_REG(5'd30), .MUL_EXC_CODE(32'd4), .DIV_EXC_CODE(32'd5), .TIMEOUT(64)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_div(in_is_div),
      .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .stall(stall),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_mul, exp_div, exp_wbv;
   logic [4:0]  exp_wbrd;
   logic [31:0] exp_wbdata, exp_opa, exp_opb;
   logic [31:0] cur_a = '0, cur_b = '0;
   int          n_cmp = 0, n_err = 0;
   int          ctrl_pulses = 0, wb_pulses = 0;
   logic [4:0]  last_wb_rd = '0;
   logic [31:0] last_wb_data = '0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         cmp("stall", 32'(stall), 32'(exp_stall));
         cmp("md_ctrl_MULT", 32'(md_ctrl_MULT), 32'(exp_mul));
         cmp("md_ctrl_DIV", 32'(md_ctrl_DIV), 32'(exp_div));
         cmp("md_operandA", md_operandA, exp_opa);
         cmp("md_operandB", md_operandB, exp_opb);
         cmp("wb_valid", 32'(wb_valid), 32'(exp_wbv));
         cmp("wb_rd", 32'(wb_rd), 32'(exp_wbrd));
         cmp("wb_data", wb_data, exp_wbdata);
      end
      if (md_ctrl_MULT || md_ctrl_DIV) ctrl_pulses++;
      if (wb_valid) begin
         wb_pulses++;
         last_wb_rd   = wb_rd;
         last_wb_data = wb_data;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] md_model(input logic div, input logic [31:0] a, input logic [31:0] b);
      if (!div) return a * b;
      if (b == '0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return '0;
      return $signed(a) / $signed(b);
   endfunction

   task automatic exp_quiet(input logic st);
      exp_stall = st; exp_mul = 1'b0; exp_div = 1'b0;
      exp_wbv = 1'b0; exp_wbrd = '0; exp_wbdata = '0;
      exp_opa = cur_a; exp_opb = cur_b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         md_resultRDY = 1'($urandom);
         md_result = $urandom;
         md_exception = 1'($urandom);
         exp_quiet(1'b0);
         tick();
      end
   endtask

   // d = BUSY cycle (1..TMO) in which ready is presented; anything else means never.
   task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int d, input logic exc,
                         input logic stale, input logic hold);
      logic [31:0] res;
      logic        tmo, e;
      int          n;
      res = md_model(div, a, b);
      tmo = !(d >= 1 && d <= TMO);
      n   = tmo ? TMO : d;
      in_valid = 1'b1; in_is_div = div; in_opA = a; in_opB = b; in_rd = rd;
      md_resultRDY = 1'b0;
      exp_quiet(1'b1);
      tick();
      cur_a = a; cur_b = b;
      in_valid = hold;
      in_opA = $urandom; in_opB = $urandom; in_rd = 5'($urandom); in_is_div = 1'($urandom);
      md_resultRDY = stale; md_result = $urandom; md_exception = 1'($urandom);
      exp_quiet(1'b1);
      exp_mul = ~div; exp_div = div;
      tick();
      for (int c = 1; c <= n; c++) begin
         exp_quiet(1'b1);
         if (!tmo && c == d) begin
            md_resultRDY = 1'b1; md_result = res; md_exception = exc;
         end else begin
            md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'($urandom);
         end
         tick();
      end
      e = tmo | exc;
      in_valid = hold;
      md_resultRDY = 1'($urandom); md_result = $urandom; md_exception = 1'($urandom);
      exp_quiet(1'b0);
      exp_wbv    = e || (rd != '0);
      exp_wbrd   = e ? 5'd30 : rd;
      exp_wbdata = e ? (div ? 32'd5 : 32'd4) : res;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, time %0t expected below 2000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, w0;
      #1 reset = 1'b0;
      in_valid = 1'b1;
      exp_quiet(1'b0);
      chk_en = 1'b1;
      tick(); tick();
      reset = 1'b1;
      idle(2);

      // Mult 7 * -3, ready after 33 BUSY cycles
      c0 = ctrl_pulses; w0 = wb_pulses;
      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 1'b0, 1'b0, 1'b0);
      cmp("mul_rd", 32'(last_wb_rd), 32'd5);
      cmp("mul_data", last_wb_data, 32'hFFFF_FFEB);
      cmp("mul_ctrl_pulses", 32'(ctrl_pulses - c0), 32'd1);
      cmp("mul_wb_pulses", 32'(wb_pulses - w0), 32'd1);
      idle(2);

      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 20, 1'b1, 1'b0, 1'b0);
      cmp("divovf_rd", 32'(last_wb_rd), 32'd30);
      cmp("divovf_data", last_wb_data, 32'd5);
      run_op(1'b0, 32'h4000_0000, 32'd4, 5'd12, 10, 1'b1, 1'b0, 1'b0);
      cmp("mulovf_rd", 32'(last_wb_rd), 32'd30);
      cmp("mulovf_data", last_wb_data, 32'd4);
      idle(1);

      // Timeouts, with a stale ready during START
      run_op(1'b0, 32'd3, 32'd5, 5'd4, 0, 1'b0, 1'b1, 1'b0);
      cmp("tmo_mul_data", last_wb_data, 32'd4);
      run_op(1'b1, 32'd3, 32'd5, 5'd4, 0, 1'b0, 1'b1, 1'b0);
      cmp("tmo_div_rd", 32'(last_wb_rd), 32'd30);
      cmp("tmo_div_data", last_wb_data, 32'd5);
      run_op(1'b0, 32'd11, 32'd13, 5'd6, 1, 1'b0, 1'b1, 1'b0);
      cmp("ready1_data", last_wb_data, 32'd143);
      run_op(1'b1, 32'd1000, 32'd10, 5'd7, TMO, 1'b0, 1'b0, 1'b0);
      cmp("ready64_data", last_wb_data, 32'd100);

      // Reset during BUSY abandons the operation
      w0 = wb_pulses;
      in_valid = 1'b1; in_is_div = 1'b0; in_opA = 32'd9; in_opB = 32'd9; in_rd = 5'd2;
      exp_quiet(1'b1);
      tick();
      cur_a = 32'd9; cur_b = 32'd9;
      in_valid = 1'b0; md_resultRDY = 1'b0;
      exp_quiet(1'b1); exp_mul = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin exp_quiet(1'b1); tick(); end
      reset = 1'b0; in_valid = 1'b1; md_resultRDY = 1'b1;
      cur_a = '0; cur_b = '0;
      exp_quiet(1'b0);
      #1;
      cmp("rst_stall_now", 32'(stall), 32'd0);
      cmp("rst_opA_now", md_operandA, 32'd0);
      cmp("rst_wbv_now", 32'(wb_valid), 32'd0);
      tick(); tick();
      reset = 1'b1; in_valid = 1'b0;
      idle(3);
      cmp("rst_no_wb", 32'(wb_pulses - w0), 32'd0);
      run_op(1'b1, 32'd100, 32'd7, 5'd3, 6, 1'b0, 1'b0, 1'b0);
      cmp("post_rst_rd", 32'(last_wb_rd), 32'd3);
      cmp("post_rst_data", last_wb_data, 32'd14);

      // Back-to-back with in_valid held through DONE
      c0 = ctrl_pulses; w0 = wb_pulses;
      run_op(1'b1, 32'd50, 32'd5, 5'd7, 5, 1'b0, 1'b0, 1'b1);
      run_op(1'b0, 32'd6, 32'd7, 5'd8, 3, 1'b0, 1'b0, 1'b0);
      cmp("b2b_ctrl", 32'(ctrl_pulses - c0), 32'd2);
      cmp("b2b_wb", 32'(wb_pulses - w0), 32'd2);
      cmp("b2b_data", last_wb_data, 32'd42);
      w0 = wb_pulses;
      run_op(1'b0, 32'd3, 32'd4, 5'd0, 4, 1'b0, 1'b0, 1'b0);
      cmp("rd0_no_wb", 32'(wb_pulses - w0), 32'd0);
      idle(1);

      for (int k = 0; k < 40; k++) begin
         run_op(1'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom,
                5'($urandom), int'($urandom_range(1, 70)), ($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom));
         idle(int'($urandom_range(0, 2)));
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter RSTATUS_REG, default 5'd30, destination register for exception status writes.
REQ-002 SHALL have parameter MUL_EXC_CODE, default 32'd4, status value written on mult exception.
REQ-003 SHALL have parameter DIV_EXC_CODE, default 32'd5, status value written on div exception.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum BUSY cycles before a forced exception.
REQ-005 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  execute stage presents a mult/div instruction.
REQ-008 SHALL have port in_is_div  input  1  1 = div, 0 = mult.
REQ-009 SHALL have ports in_opA, in_opB  input  32  signed operands.
REQ-010 SHALL have port in_rd  input  5  destination register.
REQ-011 SHALL have port stall  output  1  hold the fetch/decode/execute stages.
REQ-012 SHALL have ports md_operandA, md_operandB  output  32  operands to multdiv.
REQ-013 SHALL have ports md_ctrl_MULT, md_ctrl_DIV  output  1  start pulses to multdiv.
REQ-014 SHALL have ports md_result  input  32, md_exception  input  1, md_resultRDY  input  1, driven by multdiv.
REQ-015 SHALL have ports wb_valid  output  1, wb_rd  output  5, wb_data  output  32, the writeback request.

Function
REQ-016 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-017 IDLE: on in_valid=1, latch in_opA/in_opB/in_is_div/in_rd and go to START; otherwise stay in IDLE.
REQ-018 START: assert exactly one of md_ctrl_MULT or md_ctrl_DIV (per the latched in_is_div) for exactly one cycle, then go to BUSY.
REQ-019 md_operandA/B SHALL drive the latched operands, held stable from START through DONE.
REQ-020 md_resultRDY SHALL be ignored in START; this covers stale ready from a previous operation.
REQ-021 BUSY: on md_resultRDY=1, capture md_result and md_exception and go to DONE.
REQ-022 BUSY SHALL count cycles from 1; at count == TIMEOUT without ready, go to DONE with exception forced to 1.
REQ-023 DONE: assert wb_valid for one cycle, then go to IDLE; in_valid SHALL be ignored in DONE, so the same instruction is not relaunched.
REQ-024 On exception in DONE: wb_rd = RSTATUS_REG and wb_data = DIV_EXC_CODE if div, else MUL_EXC_CODE.
REQ-025 On no exception in DONE: wb_rd = latched rd and wb_data = captured result; wb_valid = 0 if latched rd = 0.
REQ-026 stall SHALL be 1 in IDLE when in_valid=1, and 1 throughout START and BUSY; 0 in DONE and in IDLE without in_valid.
REQ-027 Latency: with in_valid sampled at edge 0 and md_resultRDY seen in BUSY at edge k, wb_valid SHALL be high in the cycle after edge k.
REQ-028 Outside DONE, wb_valid SHALL be 0; md_ctrl_* SHALL be 0 outside START.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE and clear all latches, the counter and every output to 0, with stall=0 while reset is low.
REQ-030 Reset asserted mid-operation (START, BUSY or DONE) SHALL abandon the operation with no wb_valid; any later md_resultRDY in IDLE SHALL be ignored.
REQ-031 After reset releases, the first in_valid SHALL be handled per REQ-017.

Verification
REQ-032 Mult: opA=7, opB=-3, rd=5, multdiv ready after 33 cycles -> one-cycle md_ctrl_MULT, stall high until DONE, wb_rd=5, wb_data=32'hFFFFFFEB.
REQ-033 Div overflow: opA=-2147483648, opB=-1, md_exception=1 -> wb_rd=30, wb_data=5.
REQ-034 Mult overflow: opA=32'h40000000, opB=4, md_exception=1 -> wb_rd=30, wb_data=4.
REQ-035 md_resultRDY held 0 -> DONE after 64 BUSY cycles, wb_rd=30, wb_data per op; md_resultRDY=1 during START -> ignored, FSM stays on course.
REQ-036 reset=0 in BUSY -> all outputs 0 at once, no wb_valid; after release, div 100/7 rd=3 -> wb_rd=3, wb_data=14.
REQ-037 Back-to-back: in_valid held through DONE, then a new mult -> exactly two ctrl pulses and two wb_valid pulses; rd=0 without exception -> wb_valid stays 0.
